// File: rtl/span_rasterizer.sv
// Multi-lane span rasterizer: tests LANES adjacent pixel centres per cycle against
// three edge equations and serialises covered pixels into a valid/ready fragment stream.

package celery_pkg;
  localparam int FX_FRAC = 16;
  localparam int COORD_W = 12;

  typedef logic signed [31:0] fx_t;  // signed Q15.16
  typedef logic [COORD_W-1:0] coord_t;

  // Attribute slots 0..5 are u, v, r, g, b, z; attr0 is the value at the origin.
  typedef struct packed {
    logic       valid;
    fx_t [2:0]  ea;
    fx_t [2:0]  eb;
    fx_t [2:0]  ec;
    logic [2:0] top_left;
    logic       ccw;
    coord_t     min_x;
    coord_t     max_x;
    coord_t     min_y;
    coord_t     max_y;
    fx_t [5:0]  attr0;
    fx_t [5:0]  dadx;
    fx_t [5:0]  dady;
  } triangle_setup_t;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
    fx_t    z;
    fx_t    u;
    fx_t    v;
    fx_t    r;
    fx_t    g;
    fx_t    b;
  } fragment_t;

  function automatic fx_t fx_mul(input fx_t a, input fx_t b);
    logic signed [63:0] p;
    p = a * b;
    return fx_t'(p >>> FX_FRAC);
  endfunction

  function automatic fx_t fx_centre(input coord_t c);
    return fx_t'({{(32 - COORD_W - FX_FRAC){1'b0}}, c, 1'b1, {(FX_FRAC - 1){1'b0}}});
  endfunction

  // k*a for a small non-negative integer k, built from shifts and adds.
  function automatic fx_t fx_lane(input fx_t a, input logic [3:0] k);
    fx_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) r = r + (a <<< i);
    end
    return r;
  endfunction

  function automatic logic edge_in(input fx_t e, input logic tl, input logic ccw);
    if (ccw) return (e > 0) || ((e == 0) && tl);
    else     return (e < 0) || ((e == 0) && !tl);
  endfunction
endpackage

module span_rasterizer
  import celery_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int COUNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  triangle_setup_t      tri_in,
  input  logic                 start,
  input  logic                 abort,
  output fragment_t            frag_out,
  output logic                 frag_valid,
  input  logic                 frag_ready,
  output logic                 done,
  output logic                 busy,
  output logic [COUNT_W-1:0]   frag_count
);

  localparam int LSH = $clog2(LANES);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SCAN, S_EMIT, S_NEXT_ROW, S_DONE} state_t;

  state_t               state_q, state_d;
  coord_t               x_q, x_d, y_q, y_d;
  coord_t               min_x_q, min_x_d, max_x_q, max_x_d, min_y_q, min_y_d, max_y_q, max_y_d;
  fx_t [2:0]            a_q, a_d, b_q, b_d, e_q, e_d, e_row_q, e_row_d;
  fx_t [5:0]            at_q, at_d, at_row_q, at_row_d;
  logic                 ccw_q, ccw_d;
  logic [LANES-1:0]     mask_q, mask_d;
  fragment_t            frag_q, frag_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [LANES-1:0]     scan_mask, rem_mask, pick_mask;
  logic [3:0]           pick_idx;
  fragment_t            pick_frag;
  fx_t                  cx, cy;
  logic                 advance, adv_more;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    fx_t [2:0] e_lane;
    logic      in_box;
    always_comb begin
      for (int j = 0; j < 3; j++) e_lane[j] = e_q[j] + fx_lane(a_q[j], 4'(gi));
    end
    assign in_box = ({1'b0, x_q} + (COORD_W+1)'(gi)) <= {1'b0, max_x_q};
    assign scan_mask[gi] = in_box
                         & edge_in(e_lane[0], tri_in.top_left[0], ccw_q)
                         & edge_in(e_lane[1], tri_in.top_left[1], ccw_q)
                         & edge_in(e_lane[2], tri_in.top_left[2], ccw_q);
  end

  // In EMIT the next fragment is picked from the mask with the current lane removed,
  // so a new fragment can be registered on the same edge as the handshake.
  assign rem_mask  = mask_q & (mask_q - LANES'(1));
  assign pick_mask = (state_q == S_EMIT) ? rem_mask : scan_mask;
  assign cx        = fx_centre(x_q);
  assign cy        = fx_centre(y_q);
  assign adv_more  = ({1'b0, x_q} + (COORD_W+1)'(LANES)) <= {1'b0, max_x_q};

  always_comb begin
    pick_idx = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (pick_mask[k]) pick_idx = 4'(k);
    end
  end

  always_comb begin
    pick_frag       = '0;
    pick_frag.valid = 1'b1;
    pick_frag.x     = x_q + COORD_W'(pick_idx);
    pick_frag.y     = y_q;
    pick_frag.u     = at_q[0] + fx_lane(tri_in.dadx[0], pick_idx);
    pick_frag.v     = at_q[1] + fx_lane(tri_in.dadx[1], pick_idx);
    pick_frag.r     = at_q[2] + fx_lane(tri_in.dadx[2], pick_idx);
    pick_frag.g     = at_q[3] + fx_lane(tri_in.dadx[3], pick_idx);
    pick_frag.b     = at_q[4] + fx_lane(tri_in.dadx[4], pick_idx);
    pick_frag.z     = at_q[5] + fx_lane(tri_in.dadx[5], pick_idx);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    min_x_d  = min_x_q;
    max_x_d  = max_x_q;
    min_y_d  = min_y_q;
    max_y_d  = max_y_q;
    a_d      = a_q;
    b_d      = b_q;
    e_d      = e_q;
    e_row_d  = e_row_q;
    at_d     = at_q;
    at_row_d = at_row_q;
    ccw_d    = ccw_q;
    mask_d   = mask_q;
    frag_d   = frag_q;
    count_d  = count_q;
    advance  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && tri_in.valid) begin
          a_d     = tri_in.ea;
          b_d     = tri_in.eb;
          ccw_d   = tri_in.ccw;
          min_x_d = tri_in.min_x;
          max_x_d = tri_in.max_x;
          min_y_d = tri_in.min_y;
          max_y_d = tri_in.max_y;
          x_d     = tri_in.min_x;
          y_d     = tri_in.min_y;
          count_d = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        for (int j = 0; j < 3; j++) begin
          e_d[j]     = fx_mul(a_q[j], cx) + fx_mul(b_q[j], cy) + tri_in.ec[j];
          e_row_d[j] = e_d[j];
        end
        for (int i = 0; i < 6; i++) begin
          at_d[i]     = tri_in.attr0[i] + fx_mul(tri_in.dadx[i], cx) + fx_mul(tri_in.dady[i], cy);
          at_row_d[i] = at_d[i];
        end
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (|scan_mask) begin
          mask_d  = scan_mask;
          frag_d  = pick_frag;
          state_d = S_EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_EMIT: begin
        if (frag_q.valid && frag_ready) begin
          count_d = count_q + COUNT_W'(1);
          mask_d  = rem_mask;
          if (|rem_mask) begin
            frag_d = pick_frag;
          end else begin
            frag_d.valid = 1'b0;
            advance      = 1'b1;
          end
        end
      end
      S_NEXT_ROW: begin
        y_d = y_q + COORD_W'(1);
        x_d = min_x_q;
        for (int j = 0; j < 3; j++) begin
          e_row_d[j] = e_row_q[j] + b_q[j];
          e_d[j]     = e_row_d[j];
        end
        for (int i = 0; i < 6; i++) begin
          at_row_d[i] = at_row_q[i] + tri_in.dady[i];
          at_d[i]     = at_row_d[i];
        end
        state_d = S_SCAN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (adv_more) begin
        x_d = x_q + COORD_W'(LANES);
        for (int j = 0; j < 3; j++) e_d[j] = e_q[j] + (a_q[j] <<< LSH);
        for (int i = 0; i < 6; i++) at_d[i] = at_q[i] + (tri_in.dadx[i] <<< LSH);
        state_d = S_SCAN;
      end else if (y_q >= max_y_q) begin
        state_d = S_DONE;
      end else begin
        state_d = S_NEXT_ROW;
      end
    end

    // Abort wins over a same-cycle handshake: that fragment is neither counted nor kept.
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      frag_d.valid = 1'b0;
      count_d      = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      min_x_q  <= '0;
      max_x_q  <= '0;
      min_y_q  <= '0;
      max_y_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      e_q      <= '0;
      e_row_q  <= '0;
      at_q     <= '0;
      at_row_q <= '0;
      ccw_q    <= 1'b0;
      mask_q   <= '0;
      frag_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      min_x_q  <= min_x_d;
      max_x_q  <= max_x_d;
      min_y_q  <= min_y_d;
      max_y_q  <= max_y_d;
      a_q      <= a_d;
      b_q      <= b_d;
      e_q      <= e_d;
      e_row_q  <= e_row_d;
      at_q     <= at_d;
      at_row_q <= at_row_d;
      ccw_q    <= ccw_d;
      mask_q   <= mask_d;
      frag_q   <= frag_d;
      count_q  <= count_d;
    end
  end

  assign frag_out   = frag_q;
  assign frag_valid = frag_q.valid;
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign frag_count = count_q;

endmodule

// File: tb/tb_span_rasterizer.sv
// Bench for span_rasterizer: LANES=4 main instance plus LANES=1/2/8 instances for the
// lane sweep, all checked against a direct-formula raster-order model.

module tb_span_rasterizer;
  import celery_pkg::*;

  localparam int BUDGET = 3000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  triangle_setup_t tri_in;
  logic            start, start_sw, abort, frag_ready;
  fragment_t       frag_out;
  logic            frag_valid, done, busy;
  logic [31:0]     frag_count;

  fragment_t       sw_out   [3];
  logic            sw_valid [3];
  logic            sw_done  [3];
  logic            sw_busy  [3];
  logic [31:0]     sw_count [3];

  int              n_cmp = 0;
  int              n_bad = 0;
  int              done_cnt = 0;
  fragment_t       exp_q[$];
  fragment_t       sw_q[3][$];

  always #5 clk = ~clk;

  span_rasterizer #(.LANES(4), .COUNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .tri_in(tri_in), .start(start), .abort(abort),
    .frag_out(frag_out), .frag_valid(frag_valid), .frag_ready(frag_ready),
    .done(done), .busy(busy), .frag_count(frag_count)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    span_rasterizer #(.LANES(gi == 0 ? 1 : (gi == 1 ? 2 : 8)), .COUNT_W(32)) u_sw (
      .clk(clk), .rst_n(rst_n), .tri_in(tri_in), .start(start_sw), .abort(1'b0),
      .frag_out(sw_out[gi]), .frag_valid(sw_valid[gi]), .frag_ready(1'b1),
      .done(sw_done[gi]), .busy(sw_busy[gi]), .frag_count(sw_count[gi])
    );
  end

  // Sweep instances always have ready=1, so every valid cycle is a handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sw_valid[i] === 1'b1) sw_q[i].push_back(sw_out[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  function automatic fx_t mdl_mul(input fx_t a, input fx_t b);
    longint p;
    p = longint'(a) * longint'(b);
    return fx_t'(p >>> 16);
  endfunction

  function automatic bit mdl_in(input fx_t e, input logic tl, input logic ccw);
    if (ccw) return (e > 0) || (e == 0 && tl);
    return (e < 0) || (e == 0 && !tl);
  endfunction

  // LANES=1 golden: every value evaluated directly at (x,y) from the bbox-corner value.
  function automatic void model(input triangle_setup_t t);
    fx_t cx0, cy0, e;
    fx_t a0 [6];
    fragment_t f;
    bit in;
    int dx, dy;
    cx0 = fx_t'(int'(t.min_x) * 65536 + 32768);
    cy0 = fx_t'(int'(t.min_y) * 65536 + 32768);
    for (int i = 0; i < 6; i++)
      a0[i] = t.attr0[i] + mdl_mul(t.dadx[i], cx0) + mdl_mul(t.dady[i], cy0);
    for (int y = int'(t.min_y); y <= int'(t.max_y); y++) begin
      for (int x = int'(t.min_x); x <= int'(t.max_x); x++) begin
        dx = x - int'(t.min_x);
        dy = y - int'(t.min_y);
        in = 1'b1;
        for (int j = 0; j < 3; j++) begin
          e = mdl_mul(t.ea[j], cx0) + mdl_mul(t.eb[j], cy0) + t.ec[j] + dx * t.ea[j] + dy * t.eb[j];
          if (!mdl_in(e, t.top_left[j], t.ccw)) in = 1'b0;
        end
        if (in) begin
          f = '0;
          f.valid = 1'b1;
          f.x = coord_t'(x);
          f.y = coord_t'(y);
          f.u = a0[0] + dx * t.dadx[0] + dy * t.dady[0];
          f.v = a0[1] + dx * t.dadx[1] + dy * t.dady[1];
          f.r = a0[2] + dx * t.dadx[2] + dy * t.dady[2];
          f.g = a0[3] + dx * t.dadx[3] + dy * t.dady[3];
          f.b = a0[4] + dx * t.dadx[4] + dy * t.dady[4];
          f.z = a0[5] + dx * t.dadx[5] + dy * t.dady[5];
          exp_q.push_back(f);
        end
      end
    end
  endfunction

  function automatic triangle_setup_t base_tri(input int x0, input int x1, input int y0, input int y1);
    triangle_setup_t t;
    t = '0;
    t.valid = 1'b1;
    t.ccw = 1'b1;
    for (int j = 0; j < 3; j++) t.ec[j] = 32'sh0001_0000;
    t.min_x = coord_t'(x0);
    t.max_x = coord_t'(x1);
    t.min_y = coord_t'(y0);
    t.max_y = coord_t'(y1);
    for (int i = 0; i < 6; i++) begin
      t.attr0[i] = fx_t'((i + 1) * 65536 + 123);
      t.dadx[i]  = fx_t'(32768 + i * 4099);
      t.dady[i]  = fx_t'(-(i + 1) * 16411);
    end
    return t;
  endfunction

  function automatic triangle_setup_t rand_tri();
    triangle_setup_t t;
    int mx, my;
    mx = int'($urandom_range(0, 10));
    my = int'($urandom_range(0, 5));
    t = base_tri(mx, mx + int'($urandom_range(0, 15)), my, my + int'($urandom_range(0, 4)));
    t.ccw = 1'($urandom_range(0, 1));
    for (int j = 0; j < 3; j++) begin
      t.ea[j] = fx_t'(int'($urandom_range(0, 262143)) - 131072);
      t.eb[j] = fx_t'(int'($urandom_range(0, 262143)) - 131072);
      t.ec[j] = fx_t'(int'($urandom_range(0, 2097151)) - 1048576);
      t.top_left[j] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 6; i++) t.dadx[i] = fx_t'($urandom);
    return t;
  endfunction

  task automatic start_tri(input triangle_setup_t t, input logic sw);
    tri_in   = t;
    start    = 1'b1;
    start_sw = sw;
    tick();
    start    = 1'b0;
    start_sw = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp += 5;
    if (frag_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b required 0", frag_valid); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b required 0", done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b required 0", busy); end
    if (frag_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d required 0", frag_count); end
    if (frag_out !== fragment_t'('0)) begin n_bad++; $display("FAIL reset_frag got %h required 0", frag_out); end
    rst_n = 1'b1;
    tick();
    $display("reset: checked idle outputs");
  endtask

  task automatic test_full_cover();
    fragment_t e;
    int cyc = 0;
    model(base_tri(0, 5, 0, 1));
    done_cnt = 0;
    frag_ready = 1'b1;
    start_tri(base_tri(0, 5, 0, 1), 1'b0);
    while (busy && cyc < BUDGET) begin
      if (frag_valid && frag_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL full_cover extra frag x=%0d y=%0d required none", frag_out.x, frag_out.y); end
        else begin
          e = exp_q.pop_front();
          if (frag_out !== e) begin n_bad++; $display("FAIL full_cover frag got x=%0d y=%0d %h required x=%0d y=%0d %h", frag_out.x, frag_out.y, frag_out, e.x, e.y, e); end
        end
      end
      tick();
      cyc++;
    end
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL full_cover timeout busy=%b required 0", busy); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL full_cover missing got %0d left required 0", exp_q.size()); end
    if (done_cnt != 1) begin n_bad++; $display("FAIL full_cover done_pulses got %0d required 1", done_cnt); end
    if (frag_count !== 32'd12) begin n_bad++; $display("FAIL full_cover count got %0d required 12", frag_count); end
    exp_q.delete();
    $display("full_cover: count=%0d done_pulses=%0d", frag_count, done_cnt);
  endtask

  task automatic test_sliver();
    triangle_setup_t t;
    fragment_t e;
    int cyc = 0;
    int done_at = -1;
    t = base_tri(0, 15, 0, 1);
    t.ea[0] = 32'sh0001_0000;  t.ec[0] = -32'sh0009_0000;
    t.ea[1] = -32'sh0001_0000; t.ec[1] = 32'sh000B_0000;
    model(t);
    done_cnt = 0;
    frag_ready = 1'b1;
    start_tri(t, 1'b0);
    while (busy && cyc < BUDGET) begin
      if (frag_valid && frag_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL sliver extra frag x=%0d y=%0d required none", frag_out.x, frag_out.y); end
        else begin
          e = exp_q.pop_front();
          if (frag_out !== e) begin n_bad++; $display("FAIL sliver frag got x=%0d y=%0d %h required x=%0d y=%0d %h", frag_out.x, frag_out.y, frag_out, e.x, e.y, e); end
        end
      end
      tick();
      cyc++;
      if (done === 1'b1 && done_at < 0) done_at = cyc;
    end
    // Covered x=9,10 per row: 2 rows x 4 spans SCAN + 4 EMIT + 1 NEXT_ROW, DONE next.
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL sliver missing got %0d left required 0", exp_q.size()); end
    if (done_at != 14) begin n_bad++; $display("FAIL sliver cycles got %0d required 14", done_at); end
    if (frag_count !== 32'd4) begin n_bad++; $display("FAIL sliver count got %0d required 4", frag_count); end
    exp_q.delete();
    $display("sliver: done after %0d cycles, count=%0d", done_at, frag_count);
  endtask

  task automatic test_backpressure();
    fragment_t e, hold;
    int cyc = 0;
    int nhs = 0;
    bit stalled = 1'b0;
    model(base_tri(0, 5, 0, 1));
    done_cnt = 0;
    frag_ready = 1'b1;
    start_tri(base_tri(0, 5, 0, 1), 1'b0);
    while (busy && cyc < BUDGET) begin
      if (nhs == 2 && !stalled && frag_valid) begin
        stalled = 1'b1;
        hold = frag_out;
        frag_ready = 1'b0;
        repeat (5) begin
          tick();
          n_cmp += 3;
          if (frag_out !== hold) begin n_bad++; $display("FAIL stall_stable got %h required %h", frag_out, hold); end
          if (frag_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid got %b required 1", frag_valid); end
          if (frag_count !== 32'd2) begin n_bad++; $display("FAIL stall_count got %0d required 2", frag_count); end
        end
        frag_ready = 1'b1;
      end
      if (frag_valid && frag_ready) begin
        n_cmp++;
        nhs++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL backpressure extra frag x=%0d y=%0d required none", frag_out.x, frag_out.y); end
        else begin
          e = exp_q.pop_front();
          if (frag_out !== e) begin n_bad++; $display("FAIL backpressure frag got x=%0d y=%0d %h required x=%0d y=%0d %h", frag_out.x, frag_out.y, frag_out, e.x, e.y, e); end
        end
      end
      tick();
      cyc++;
    end
    n_cmp += 3;
    if (!stalled) begin n_bad++; $display("FAIL backpressure no_stall got 0 required 1"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL backpressure missing got %0d left required 0", exp_q.size()); end
    if (frag_count !== 32'd12) begin n_bad++; $display("FAIL backpressure count got %0d required 12", frag_count); end
    exp_q.delete();
    $display("backpressure: count=%0d", frag_count);
  endtask

  task automatic test_abort();
    fragment_t e;
    int cyc = 0;
    int nhs = 0;
    bit aborted = 1'b0;
    model(base_tri(0, 5, 0, 1));
    done_cnt = 0;
    frag_ready = 1'b1;
    start_tri(base_tri(0, 5, 0, 1), 1'b0);
    while (busy && cyc < BUDGET && !aborted) begin
      if (nhs == 3 && frag_valid) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        aborted = 1'b1;
      end else begin
        if (frag_valid && frag_ready) begin
          n_cmp++;
          nhs++;
          e = exp_q.pop_front();
          if (frag_out !== e) begin n_bad++; $display("FAIL abort_pre frag got x=%0d y=%0d required x=%0d y=%0d", frag_out.x, frag_out.y, e.x, e.y); end
        end
        tick();
        cyc++;
      end
    end
    n_cmp += 5;
    if (!aborted) begin n_bad++; $display("FAIL abort not_reached got 0 required 1"); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b required 0", busy); end
    if (frag_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid got %b required 0", frag_valid); end
    if (frag_count !== 32'd3) begin n_bad++; $display("FAIL abort_count got %0d required 3", frag_count); end
    tick();
    if (done_cnt != 0) begin n_bad++; $display("FAIL abort_done got %0d pulses required 0", done_cnt); end
    exp_q.delete();
    $display("abort: count=%0d busy=%b", frag_count, busy);

    model(base_tri(7, 7, 3, 3));
    start_tri(base_tri(7, 7, 3, 3), 1'b0);
    cyc = 0;
    while (busy && cyc < BUDGET) begin
      if (frag_valid && frag_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL after_abort extra frag x=%0d y=%0d required none", frag_out.x, frag_out.y); end
        else begin
          e = exp_q.pop_front();
          if (frag_out !== e) begin n_bad++; $display("FAIL after_abort frag got x=%0d y=%0d required x=%0d y=%0d", frag_out.x, frag_out.y, e.x, e.y); end
        end
      end
      tick();
      cyc++;
    end
    n_cmp += 2;
    if (frag_count !== 32'd1) begin n_bad++; $display("FAIL after_abort count got %0d required 1", frag_count); end
    if (done_cnt != 1) begin n_bad++; $display("FAIL after_abort done got %0d pulses required 1", done_cnt); end
    exp_q.delete();
    $display("restart after abort: count=%0d", frag_count);
  endtask

  task automatic test_single_pixel();
    triangle_setup_t t;
    fragment_t e;
    int cyc;
    int req [5] = '{1, 0, 0, 1, 1};
    for (int v = 0; v < 5; v++) begin
      t = base_tri(7, 7, 3, 3);
      case (v)
        1: t.ec[0] = -32'sh0001_0000;
        2: begin t.ec[0] = '0; t.top_left[0] = 1'b0; end
        3: begin t.ec[0] = '0; t.top_left[0] = 1'b1; end
        4: begin t.ccw = 1'b0; for (int j = 0; j < 3; j++) t.ec[j] = -32'sh0001_0000; end
        default: ;
      endcase
      model(t);
      done_cnt = 0;
      frag_ready = 1'b1;
      start_tri(t, 1'b0);
      cyc = 0;
      while (busy && cyc < BUDGET) begin
        if (frag_valid && frag_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin n_bad++; $display("FAIL pixel%0d extra frag x=%0d y=%0d required none", v, frag_out.x, frag_out.y); end
          else begin
            e = exp_q.pop_front();
            if (frag_out !== e) begin n_bad++; $display("FAIL pixel%0d frag got x=%0d y=%0d required x=%0d y=%0d", v, frag_out.x, frag_out.y, e.x, e.y); end
          end
        end
        tick();
        cyc++;
      end
      n_cmp += 2;
      if (frag_count !== 32'(req[v])) begin n_bad++; $display("FAIL pixel%0d count got %0d required %0d", v, frag_count, req[v]); end
      if (done_cnt != 1) begin n_bad++; $display("FAIL pixel%0d done got %0d pulses required 1", v, done_cnt); end
      exp_q.delete();
      $display("pixel variant %0d: count=%0d", v, frag_count);
    end
  endtask

  task automatic test_lane_sweep();
    triangle_setup_t t;
    fragment_t e;
    fragment_t ref_q[$];
    int cyc;
    for (int n = 0; n < 6; n++) begin
      t = rand_tri();
      model(t);
      ref_q = exp_q;
      for (int i = 0; i < 3; i++) sw_q[i].delete();
      done_cnt = 0;
      frag_ready = 1'b1;
      start_tri(t, 1'b1);
      cyc = 0;
      while (busy && cyc < BUDGET) begin
        if (frag_valid && frag_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin n_bad++; $display("FAIL sweep%0d L4 extra frag x=%0d y=%0d required none", n, frag_out.x, frag_out.y); end
          else begin
            e = exp_q.pop_front();
            if (frag_out !== e) begin n_bad++; $display("FAIL sweep%0d L4 got x=%0d y=%0d %h required x=%0d y=%0d %h", n, frag_out.x, frag_out.y, frag_out, e.x, e.y, e); end
          end
        end
        tick();
        cyc++;
      end
      while ((sw_busy[0] || sw_busy[1] || sw_busy[2]) && cyc < BUDGET) begin
        tick();
        cyc++;
      end
      n_cmp += 2;
      if (cyc >= BUDGET) begin n_bad++; $display("FAIL sweep%0d timeout cycles=%0d required <%0d", n, cyc, BUDGET); end
      if (exp_q.size() != 0) begin n_bad++; $display("FAIL sweep%0d L4 missing got %0d left required 0", n, exp_q.size()); end
      for (int i = 0; i < 3; i++) begin
        n_cmp += 2;
        if (sw_q[i].size() != ref_q.size()) begin n_bad++; $display("FAIL sweep%0d inst%0d length got %0d required %0d", n, i, sw_q[i].size(), ref_q.size()); end
        if (sw_count[i] !== 32'(ref_q.size())) begin n_bad++; $display("FAIL sweep%0d inst%0d count got %0d required %0d", n, i, sw_count[i], ref_q.size()); end
        for (int k = 0; k < ref_q.size() && k < sw_q[i].size(); k++) begin
          n_cmp++;
          if (sw_q[i][k] !== ref_q[k]) begin n_bad++; $display("FAIL sweep%0d inst%0d frag%0d got %h required %h", n, i, k, sw_q[i][k], ref_q[k]); end
        end
      end
      exp_q.delete();
      $display("sweep triangle %0d: %0d fragments, L4 count=%0d", n, ref_q.size(), frag_count);
    end
  endtask

  initial begin
    tri_in     = '0;
    start      = 1'b0;
    start_sw   = 1'b0;
    abort      = 1'b0;
    frag_ready = 1'b1;
    test_reset();
    test_full_cover();
    test_sliver();
    test_backpressure();
    test_abort();
    test_single_pixel();
    test_lane_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
